// File: rtl/iq_demod_accumulator_if.sv
// iq_demod_accumulator_if: sample/config/result bundle for the I/Q
// integrate-and-dump stage. The master side (DCO/ADC front end and loop
// controller) drives samples and the period register; the slave side is the
// accumulator, which returns the dumped I/Q sums and their valid strobe.
interface iq_demod_accumulator_if #(
  parameter int ADC_DATA_WIDTH = 12,
  parameter int SIN_DATA_WIDTH = 13,
  parameter int OUT_WIDTH      = 32,
  parameter int PERIOD_BITS    = 16
) ();

  logic                             CE;
  logic signed [ADC_DATA_WIDTH-1:0] ADC_VALUE;
  logic signed [SIN_DATA_WIDTH-1:0] SIN_VALUE;
  logic signed [SIN_DATA_WIDTH-1:0] COS_VALUE;
  logic        [PERIOD_BITS-1:0]    PERIOD_IN;
  logic                             PERIOD_IN_WE;
  logic signed [OUT_WIDTH-1:0]      I_OUT;
  logic signed [OUT_WIDTH-1:0]      Q_OUT;
  logic                             OUT_VALID;

  modport master (
    output CE,
    output ADC_VALUE,
    output SIN_VALUE,
    output COS_VALUE,
    output PERIOD_IN,
    output PERIOD_IN_WE,
    input  I_OUT,
    input  Q_OUT,
    input  OUT_VALID
  );

  modport slave (
    input  CE,
    input  ADC_VALUE,
    input  SIN_VALUE,
    input  COS_VALUE,
    input  PERIOD_IN,
    input  PERIOD_IN_WE,
    output I_OUT,
    output Q_OUT,
    output OUT_VALID
  );

endinterface

// File: rtl/iq_demod_accumulator.sv
// iq_demod_accumulator: quadrature demodulator / integrate-and-dump stage.
// Every CE cycle the ADC sample is multiplied by the DCO SIN and COS samples;
// both products are integrated over a window of N samples and dumped as
// scaled I/Q sums with a one-CLK OUT_VALID strobe. A window length of 0
// means idle (nothing accumulated, no strobes).
//
// Pipeline (all stages advance only on CE=1):
//   S1 registers the samples and the "last sample of window" flag,
//   S2 registers the sign-extended products,
//   S3 accumulates and, on a flagged sample, dumps acc+product and restarts.
//
// Optional feature: define IQ_DEMOD_SATURATE_EN to clamp the shifted sum to
// the signed OUT_WIDTH range; when it is undefined the low OUT_WIDTH bits are
// taken (two's-complement wrap).
//
// Assumes ACC_WIDTH >= ADC_DATA_WIDTH + SIN_DATA_WIDTH and ACC_WIDTH >= OUT_WIDTH.
module iq_demod_accumulator #(
  parameter int ADC_DATA_WIDTH = 12,
  parameter int SIN_DATA_WIDTH = 13,
  parameter int ACC_WIDTH      = 48,
  parameter int OUT_WIDTH      = 32,
  parameter int OUT_SHIFT      = 0,
  parameter int PERIOD_BITS    = 16
) (
  input logic                   CLK,
  input logic                   RESET,
  iq_demod_accumulator_if.slave bus
);

  localparam int PROD_WIDTH = ADC_DATA_WIDTH + SIN_DATA_WIDTH;

  // Window control: active length, pending (written but not yet applied)
  // length, and the position of the current sample inside the window.
  logic [PERIOD_BITS-1:0] period_active;
  logic [PERIOD_BITS-1:0] period_pending;
  logic                   pending_valid;
  logic [PERIOD_BITS-1:0] sample_count;

  logic [PERIOD_BITS-1:0] period_active_nxt;
  logic [PERIOD_BITS-1:0] period_pending_nxt;
  logic                   pending_valid_nxt;
  logic [PERIOD_BITS-1:0] sample_count_nxt;

  logic [PERIOD_BITS-1:0] period_eff;
  logic                   idle_load;
  logic                   sample_en;
  logic                   sample_last;

  // S1 registers
  logic signed [ADC_DATA_WIDTH-1:0] s1_adc;
  logic signed [SIN_DATA_WIDTH-1:0] s1_sin;
  logic signed [SIN_DATA_WIDTH-1:0] s1_cos;
  logic                             s1_valid;
  logic                             s1_last;

  // Full-width products of the S1 samples
  logic signed [PROD_WIDTH-1:0] i_prod_full;
  logic signed [PROD_WIDTH-1:0] q_prod_full;

  // S2 registers
  logic signed [ACC_WIDTH-1:0] s2_i_prod;
  logic signed [ACC_WIDTH-1:0] s2_q_prod;
  logic                        s2_valid;
  logic                        s2_last;

  // S3 accumulators and their sum with the incoming product
  logic signed [ACC_WIDTH-1:0] i_acc;
  logic signed [ACC_WIDTH-1:0] q_acc;
  logic signed [ACC_WIDTH-1:0] i_sum;
  logic signed [ACC_WIDTH-1:0] q_sum;

  // Output registers
  logic signed [OUT_WIDTH-1:0] i_out_r;
  logic signed [OUT_WIDTH-1:0] q_out_r;
  logic                        out_valid_r;

  // Scale the sum by OUT_SHIFT and reduce it to OUT_WIDTH bits.
`ifdef IQ_DEMOD_SATURATE_EN
  function automatic logic signed [OUT_WIDTH-1:0] reduce_sum(input logic signed [ACC_WIDTH-1:0] sum);
    logic signed [ACC_WIDTH-1:0] shifted;
    logic                        fits;
    shifted = sum >>> OUT_SHIFT;
    fits = (&shifted[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|shifted[ACC_WIDTH-1:OUT_WIDTH-1]);
    if (fits) begin
      reduce_sum = shifted[OUT_WIDTH-1:0];
    end else if (shifted[ACC_WIDTH-1]) begin
      reduce_sum = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      reduce_sum = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  endfunction
`else
  function automatic logic signed [OUT_WIDTH-1:0] reduce_sum(input logic signed [ACC_WIDTH-1:0] sum);
    reduce_sum = OUT_WIDTH'(sum >>> OUT_SHIFT);
  endfunction
`endif

  // Decide whether this CE cycle carries a sample, whether it closes the
  // window, and which period/pending values apply afterwards. An idle block
  // picks up a pending length on this cycle and starts the window with it;
  // a running window only swaps length at its boundary, where a write made
  // on the boundary cycle itself takes precedence over the older pending one.
  always_comb begin
    period_active_nxt  = period_active;
    period_pending_nxt = period_pending;
    pending_valid_nxt  = pending_valid;
    sample_count_nxt   = sample_count;

    idle_load   = (period_active == '0) && pending_valid;
    period_eff  = idle_load ? period_pending : period_active;
    sample_en   = (period_eff != '0);
    sample_last = sample_en && (sample_count == (period_eff - PERIOD_BITS'(1)));

    if (idle_load) begin
      period_active_nxt = period_pending;
      pending_valid_nxt = 1'b0;
    end

    if (sample_en) begin
      if (sample_last) begin
        sample_count_nxt = '0;
        if (bus.PERIOD_IN_WE) begin
          period_active_nxt  = bus.PERIOD_IN;
          period_pending_nxt = bus.PERIOD_IN;
          pending_valid_nxt  = 1'b0;
        end else if (pending_valid) begin
          period_active_nxt = period_pending;
          pending_valid_nxt = 1'b0;
        end
      end else begin
        sample_count_nxt = sample_count + PERIOD_BITS'(1);
      end
    end

    if (bus.PERIOD_IN_WE && !sample_last) begin
      period_pending_nxt = bus.PERIOD_IN;
      pending_valid_nxt  = 1'b1;
    end
  end

  // Window control state register, frozen while CE is low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      period_active  <= '0;
      period_pending <= '0;
      pending_valid  <= 1'b0;
      sample_count   <= '0;
    end else if (bus.CE) begin
      period_active  <= period_active_nxt;
      period_pending <= period_pending_nxt;
      pending_valid  <= pending_valid_nxt;
      sample_count   <= sample_count_nxt;
    end
  end

  // S1: capture the aligned samples together with the window flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_adc   <= '0;
      s1_sin   <= '0;
      s1_cos   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (bus.CE) begin
      s1_adc   <= bus.ADC_VALUE;
      s1_sin   <= bus.SIN_VALUE;
      s1_cos   <= bus.COS_VALUE;
      s1_valid <= sample_en;
      s1_last  <= sample_last;
    end
  end

  assign i_prod_full = s1_adc * s1_sin;
  assign q_prod_full = s1_adc * s1_cos;

  // S2: register the signed products, sign-extended to the accumulator width.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      s2_i_prod <= '0;
      s2_q_prod <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
    end else if (bus.CE) begin
      s2_i_prod <= {{(ACC_WIDTH-PROD_WIDTH){i_prod_full[PROD_WIDTH-1]}}, i_prod_full};
      s2_q_prod <= {{(ACC_WIDTH-PROD_WIDTH){q_prod_full[PROD_WIDTH-1]}}, q_prod_full};
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
    end
  end

  assign i_sum = i_acc + s2_i_prod;
  assign q_sum = q_acc + s2_q_prod;

  // S3: integrate; the last sample of a window goes straight into the dump
  // and the accumulators restart from zero for the next window.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      i_acc <= '0;
      q_acc <= '0;
    end else if (bus.CE && s2_valid) begin
      if (s2_last) begin
        i_acc <= '0;
        q_acc <= '0;
      end else begin
        i_acc <= i_sum;
        q_acc <= q_sum;
      end
    end
  end

  // Output stage: results hold between dumps; the strobe drops on every CLK
  // without a dump, CE=0 cycles included.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      i_out_r     <= '0;
      q_out_r     <= '0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= bus.CE && s2_valid && s2_last;
      if (bus.CE && s2_valid && s2_last) begin
        i_out_r <= reduce_sum(i_sum);
        q_out_r <= reduce_sum(q_sum);
      end
    end
  end

  assign bus.I_OUT     = i_out_r;
  assign bus.Q_OUT     = q_out_r;
  assign bus.OUT_VALID = out_valid_r;

endmodule

// File: doc/iq_demod_accumulator.md
# iq_demod_accumulator

Quadrature demodulator / integrate-and-dump stage directly downstream of the sin/cos DCO. Each CE cycle it multiplies the current ADC sample by the DCO SIN and COS samples, accumulates both products over a programmable window of N samples, then dumps scaled I/Q sums with a one-cycle valid strobe. Its outputs feed the phase/amplitude detector that closes the sensor loop.

## Interface
- ADC_DATA_WIDTH, 12: ADC sample width, signed two's complement.
- SIN_DATA_WIDTH, 13: DCO SIN/COS sample width, signed two's complement.
- ACC_WIDTH, 48: internal accumulator width.
- OUT_WIDTH, 32: I/Q output width.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator at dump.
- PERIOD_BITS, 16: window-length register width.

- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- CE  in  1  clock enable; 0 freezes the pipeline, counter and accumulators.
- ADC_VALUE  in  ADC_DATA_WIDTH  signed ADC sample, pre-aligned to the DCO outputs.
- SIN_VALUE  in  SIN_DATA_WIDTH  signed DCO sine sample.
- COS_VALUE  in  SIN_DATA_WIDTH  signed DCO cosine sample.
- PERIOD_IN  in  PERIOD_BITS  new window length N in samples.
- PERIOD_IN_WE  in  1  write strobe for PERIOD_IN, sampled only when CE=1.
- I_OUT  out  OUT_WIDTH  signed in-phase sum (ADC×SIN) of the last completed window.
- Q_OUT  out  OUT_WIDTH  signed quadrature sum (ADC×COS) of the last completed window.
- OUT_VALID  out  1  one-CLK pulse when I_OUT/Q_OUT update.

## Operation
- Reset: I_OUT=0, Q_OUT=0, OUT_VALID=0, accumulators=0, sample counter=0, active period=0, pending period=0, no pending write.
- Period 0 means idle: no accumulation and no OUT_VALID.
- PERIOD_IN_WE with CE=1 stores PERIOD_IN as the pending period.
  - When idle, the pending period is loaded on the next CE cycle and a window starts with that sample.
  - When not idle, the pending period is loaded at the next window boundary. The current window always completes at its old length.
  - A second write before the boundary overwrites the pending value.
- Pipeline, all stages advance only when CE=1:
  - S1: register ADC/SIN/COS and the "last sample" flag (counter == N-1).
  - S2: register the signed full-width products ADC×SIN and ADC×COS, sign-extended to ACC_WIDTH.
  - S3: accumulate the products. On a flagged sample, dump acc+product to the output stage and load the accumulator with 0.
- Counter: counts 0..N-1 on each S1 CE cycle, then wraps to 0 and loads the pending period if one exists.
- Dump value: the accumulator sum arithmetically shifted right by OUT_SHIFT, then reduced to OUT_WIDTH (see Configuration).
- Accumulator overflow within ACC_WIDTH wraps. Sizing ACC_WIDTH is the integrator's responsibility.
- Reset mid-window discards the partial sums. The first OUT_VALID after reset requires a complete new window.

## Timing
- Latency: the last sample of a window is presented on CE cycle t. I_OUT/Q_OUT update and OUT_VALID=1 on the CLK edge of the 3rd CE cycle after t (three CE-qualified stages).
- OUT_VALID is high for exactly one CLK. It is cleared on every CLK where no dump occurs, including CE=0 cycles.
- I_OUT/Q_OUT hold between dumps.
- With N=1 and CE continuously 1, OUT_VALID is high every cycle.
- A period write and a window boundary in the same CE cycle: the boundary loads the newly written value.
- Idle→active transition: the window starts on the CE cycle after the write, not on the write cycle.

## Configuration
- IQ_DEMOD_SATURATE_EN defined: the shifted sum is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- IQ_DEMOD_SATURATE_EN undefined: the low OUT_WIDTH bits of the shifted sum are output (two's-complement wrap).

## Test plan
- N=4, ADC=100, SIN=1000, COS=0, CE=1: I_OUT=400000 and Q_OUT=0, with OUT_VALID every 4 cycles and the first pulse 3 cycles after the 4th sample.
- N=1, ADC=-2048, SIN=-4096, COS=4095: OUT_VALID every cycle, I_OUT=8388608, Q_OUT=-8386560.
- Same stimulus as scenario 1 with CE toggling 1/0: identical I_OUT values, OUT_VALID spaced 8 CLK apart and 1 CLK wide.
- N=8 running, write N=4 at sample 3: the current window dumps after 8 samples, then windows of 4. A write of 0 returns the block to idle after the current window completes.
- OUT_WIDTH=24, OUT_SHIFT=0, N=4, ADC=2047, SIN=4095: sum 33529860 gives I_OUT=8388607 with the macro, 33529860 mod 2^24 = 16752644 as a signed value (-24572) without it.
- RESET asserted at sample 2 of a window: outputs read 0 next cycle, and no OUT_VALID until a newly written period completes a full window.
